// File: rtl/s2a_sample_packer.sv
// Decimates 12-bit I/Q sample pairs and packs the kept samples into 32-bit
// stream buffer words, with a one-cycle write strobe and optional fixed-length capture.
module s2a_sample_packer #(
  parameter int DW = 12,
  parameter int CW = 32
) (
  input  logic          Sclk,
  input  logic          rst,
  input  logic          sync,
  input  logic          enable,
  input  logic          mode,
  input  logic [7:0]    decim,
  input  logic [CW-1:0] len,
  input  logic          din_valid,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] din_q,
  output logic          Ien,
  output logic [31:0]   Idata,
  output logic [CW-1:0] word_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ien;
  logic [31:0]   r_idata;
  logic [CW-1:0] r_word_cnt;
  logic [7:0]    r_dcnt;
  logic          r_half;
  logic [15:0]   r_lo;
  logic          r_mode;
  logic [7:0]    r_decim;
  logic [CW-1:0] r_len;

  logic [7:0]    w_i8;
  logic [7:0]    w_q8;
  logic [15:0]   w_i16;
  logic [15:0]   w_q16;
  logic          w_acc;
  logic          w_keep;
  logic          w_wr;
  logic [CW-1:0] w_cnt_nx;
  logic          w_last;

  // Samples are left-justified into 16-bit lanes; byte mode keeps the top 8 bits.
  assign w_i8     = din_i[DW-1:DW-8];
  assign w_q8     = din_q[DW-1:DW-8];
  assign w_i16    = 16'(din_i) << (16 - DW);
  assign w_q16    = 16'(din_q) << (16 - DW);
  assign w_acc    = (r_state == RUN) && din_valid;
  assign w_keep   = w_acc && (r_dcnt == 8'd0);
  assign w_wr     = w_keep && (!r_mode || r_half);
  assign w_cnt_nx = r_word_cnt + CW'(1);
  assign w_last   = w_wr && (r_len != '0) && (w_cnt_nx == r_len);

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ien      <= 1'b0;
      r_idata    <= '0;
      r_word_cnt <= '0;
      r_dcnt     <= '0;
      r_half     <= 1'b0;
      r_lo       <= '0;
      r_mode     <= 1'b0;
      r_decim    <= '0;
      r_len      <= '0;
    end else if (sync) begin
      r_state    <= IDLE;
      r_ien      <= 1'b0;
      r_word_cnt <= '0;
      r_dcnt     <= '0;
      r_half     <= 1'b0;
      r_lo       <= '0;
      r_mode     <= 1'b0;
      r_decim    <= '0;
      r_len      <= '0;
    end else begin
      r_ien <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_state    <= RUN;
            r_mode     <= mode;
            r_decim    <= decim;
            r_len      <= len;
            r_dcnt     <= '0;
            r_half     <= 1'b0;
            r_word_cnt <= '0;
          end
        end
        RUN: begin
          if (w_acc) begin
            r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
          end
          if (w_keep) begin
            if (!r_mode) begin
              r_idata <= {w_q16, w_i16};
            end else if (!r_half) begin
              r_lo   <= {w_q8, w_i8};
              r_half <= 1'b1;
            end else begin
              r_idata <= {w_q8, w_i8, r_lo};
              r_half  <= 1'b0;
            end
          end
          if (w_wr) begin
            r_ien      <= 1'b1;
            r_word_cnt <= w_cnt_nx;
          end
          // A word completing on the exit edge is still written; a lone half is dropped.
          if (!enable) begin
            r_state <= IDLE;
            r_half  <= 1'b0;
          end else if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!enable) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Ien      = r_ien;
  assign Idata    = r_idata;
  assign word_cnt = r_word_cnt;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_s2a_sample_packer.sv
// Directed bench for s2a_sample_packer: reset, packing modes, decimation,
// fixed-length stop, abort and sync clear.
module tb_s2a_sample_packer;

  logic        Sclk = 1'b0;
  logic        rst;
  logic        sync;
  logic        enable;
  logic        mode;
  logic [7:0]  decim;
  logic [31:0] len;
  logic        din_valid;
  logic [11:0] din_i;
  logic [11:0] din_q;
  logic        Ien;
  logic [31:0] Idata;
  logic [31:0] word_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int ien_cnt = 0;
  logic [31:0] words[$];
  logic [31:0] last_word;

  always #5 Sclk = ~Sclk;

  s2a_sample_packer #(.DW(12), .CW(32)) dut (
    .Sclk(Sclk), .rst(rst), .sync(sync), .enable(enable),
    .mode(mode), .decim(decim), .len(len),
    .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .Ien(Ien), .Idata(Idata), .word_cnt(word_cnt),
    .busy(busy), .done(done)
  );

  always @(negedge Sclk) begin
    if (Ien) begin
      ien_cnt++;
      words.push_back(Idata);
    end
  end

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic feed(input logic [11:0] i, input logic [11:0] q);
    din_valid = 1'b1;
    din_i = i;
    din_q = q;
    tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ien_cnt = 0;
    words.delete();
  endtask

  function automatic logic [31:0] wd(input int k);
    if (k < words.size()) return words[k];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst = 1'b1; sync = 1'b0; enable = 1'b0; mode = 1'b0;
    decim = '0; len = '0; din_valid = 1'b1;
    din_i = 12'(($urandom)); din_q = 12'(($urandom));
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) feed(12'($urandom), 12'($urandom));
    din_valid = 1'b0;
    tick();
    chk("rst_ien", 64'(ien_cnt), 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idata", Idata, 0);

    // mode 0, decim 0, len 4
    clr();
    mode = 1'b0; decim = 8'd0; len = 32'd4; enable = 1'b1;
    tick();
    chk("m0_busy", busy, 1);
    feed(12'h7FF, 12'h800);
    feed(12'h001, 12'hFFF);
    feed(12'h123, 12'h456);
    feed(12'h800, 12'h7FF);
    din_valid = 1'b0;
    tick();
    chk("m0_npulse", 64'(ien_cnt), 4);
    chk("m0_w0", wd(0), 32'h8000_7FF0);
    chk("m0_w1", wd(1), 32'hFFF0_0010);
    chk("m0_w2", wd(2), 32'h4560_1230);
    chk("m0_w3", wd(3), 32'h7FF0_8000);
    chk("m0_done", done, 1);
    chk("m0_cnt", word_cnt, 4);
    chk("m0_busy_off", busy, 0);
    feed(12'h111, 12'h222);
    feed(12'h333, 12'h444);
    din_valid = 1'b0;
    tick();
    chk("m0_nowr_done", 64'(ien_cnt), 4);
    enable = 1'b0;
    tick();
    chk("m0_idle_done", done, 0);

    // mode 1, decim 2, continuous
    clr();
    mode = 1'b1; decim = 8'd2; len = 32'd0; enable = 1'b1;
    tick();
    for (int n = 0; n < 12; n++) begin
      feed(12'(n), 12'(-(n << 4)));
    end
    din_valid = 1'b0;
    tick();
    chk("m1_npulse", 64'(ien_cnt), 2);
    chk("m1_w0", wd(0), 32'hFD00_0000);
    chk("m1_w1", wd(1), 32'hF700_FA00);
    chk("m1_cnt", word_cnt, 2);
    chk("m1_busy", busy, 1);
    enable = 1'b0;
    tick();
    chk("m1_stop_busy", busy, 0);
    chk("m1_stop_cnt", word_cnt, 2);

    // fixed length 3 with continuous valid
    clr();
    mode = 1'b0; decim = 8'd0; len = 32'd3; enable = 1'b1;
    din_valid = 1'b1; din_i = 12'h0A0; din_q = 12'h0B0;
    tick();
    for (int n = 1; n <= 6; n++) feed(12'(n), 12'(n + 8));
    chk("len3_npulse", 64'(ien_cnt), 3);
    chk("len3_w2", wd(2), 32'h00B0_0030);
    chk("len3_done", done, 1);
    chk("len3_cnt", word_cnt, 3);
    din_valid = 1'b0;
    enable = 1'b0;
    tick();
    chk("len3_idle_done", done, 0);
    chk("len3_idle_busy", busy, 0);

    // abort with a pending half word, then restart
    clr();
    mode = 1'b1; decim = 8'd0; len = 32'd0; enable = 1'b1;
    tick();
    feed(12'hAB0, 12'hCD0);
    din_valid = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    chk("abort_ien", 64'(ien_cnt), 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", word_cnt, 0);
    enable = 1'b1;
    tick();
    feed(12'h120, 12'h340);
    feed(12'h560, 12'h780);
    din_valid = 1'b0;
    tick();
    chk("restart_npulse", 64'(ien_cnt), 1);
    chk("restart_w0", wd(0), 32'h7856_3412);
    enable = 1'b0;
    tick();

    // sync mid-run
    clr();
    mode = 1'b0; decim = 8'd0; len = 32'd0; enable = 1'b1;
    tick();
    feed(12'h010, 12'h020);
    feed(12'h030, 12'h040);
    feed(12'h050, 12'h060);
    chk("sync_pre_cnt", word_cnt, 3);
    last_word = 32'h0600_0500;
    sync = 1'b1;
    feed(12'h070, 12'h080);
    sync = 1'b0;
    chk("sync_cnt", word_cnt, 0);
    chk("sync_busy", busy, 0);
    chk("sync_ien", Ien, 0);
    chk("sync_idata_hold", Idata, last_word);
    din_valid = 1'b0;
    tick();
    chk("sync_npulse", 64'(ien_cnt), 3);
    chk("resync_busy", busy, 1);
    chk("resync_cnt", word_cnt, 0);
    feed(12'h0F0, 12'h0E0);
    din_valid = 1'b0;
    tick();
    chk("resync_cnt1", word_cnt, 1);
    chk("resync_w", wd(3), 32'h0E00_0F00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
